// File: rtl/spi_frame_ctrl_if.sv
// Byte-stream and write-port bundle for spi_frame_ctrl.
// The slave modport is the frame controller; master is whoever feeds it.
interface spi_frame_ctrl_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic [7:0]            byte_in;
  logic                  byte_valid_in;
  logic                  sel_in;
  logic                  wr_en_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic [7:0]            wr_data_out;
  logic                  start_out;
  logic                  frame_done_out;
  logic                  err_out;
  logic [1:0]            err_code_out;
  logic                  busy_out;

  modport master (
    output byte_in, byte_valid_in, sel_in,
    input  wr_en_out, wr_addr_out, wr_data_out, start_out,
           frame_done_out, err_out, err_code_out, busy_out
  );

  modport slave (
    input  byte_in, byte_valid_in, sel_in,
    output wr_en_out, wr_addr_out, wr_data_out, start_out,
           frame_done_out, err_out, err_code_out, busy_out
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI command-frame sequencer: OPCODE, ADDR, LEN, payload[, CSUM] -> write pulses and status.
// Define SPI_FRAME_CSUM_EN to require a trailing XOR checksum byte.
module spi_frame_ctrl #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] OP_WRITE   = 8'h01,
  parameter logic [7:0] OP_START   = 8'h02
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  spi_frame_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_LEN       = 3'd2,
    S_DATA      = 3'd3,
`ifdef SPI_FRAME_CSUM_EN
    S_CSUM      = 3'd4,
`endif
    S_CMPL      = 3'd5,
    S_DONE_WAIT = 3'd6,
    S_DROP      = 3'd7
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_remaining;
  logic                  r_is_start;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_start;
  logic                  r_done;
  logic                  r_err;
  logic [1:0]            r_err_code;
  logic                  r_busy;
`ifdef SPI_FRAME_CSUM_EN
  logic [7:0]            r_csum;
`endif

  wire w_byte_ok = bus.byte_valid_in;

  // Frame FSM; all outputs are registered pulses since the byte stream cannot stall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= 8'd0;
      r_is_start  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
      r_busy      <= 1'b0;
`ifdef SPI_FRAME_CSUM_EN
      r_csum      <= 8'd0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (bus.sel_in) begin
        // Deselect wins over any byte strobed in the same cycle.
        case (r_state)
`ifdef SPI_FRAME_CSUM_EN
          S_CSUM,
`endif
          S_ADDR, S_LEN, S_DATA: begin
            r_err      <= 1'b1;
            r_err_code <= 2'd2;
          end
          S_CMPL: begin
            r_done  <= 1'b1;
            r_start <= r_is_start;
          end
          default: ;
        endcase
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
`ifdef SPI_FRAME_CSUM_EN
        r_csum  <= 8'd0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_byte_ok) begin
`ifdef SPI_FRAME_CSUM_EN
              r_csum <= bus.byte_in;
`endif
              r_busy <= 1'b1;
              if (bus.byte_in == OP_WRITE || bus.byte_in == OP_START) begin
                r_is_start <= (bus.byte_in == OP_START);
                r_state    <= S_ADDR;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
                r_state    <= S_DROP;
              end
            end else begin
`ifdef SPI_FRAME_CSUM_EN
              r_csum <= 8'd0;
`endif
            end
          end
          S_ADDR: begin
            if (w_byte_ok) begin
              r_addr  <= bus.byte_in[ADDR_WIDTH-1:0];
`ifdef SPI_FRAME_CSUM_EN
              r_csum  <= r_csum ^ bus.byte_in;
`endif
              r_state <= S_LEN;
            end
          end
          S_LEN: begin
            if (w_byte_ok) begin
              r_remaining <= bus.byte_in;
`ifdef SPI_FRAME_CSUM_EN
              r_csum      <= r_csum ^ bus.byte_in;
`endif
              if (r_is_start && bus.byte_in != 8'd0) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
                r_state    <= S_DROP;
              end else if (bus.byte_in == 8'd0) begin
`ifdef SPI_FRAME_CSUM_EN
                r_state <= S_CSUM;
`else
                r_done  <= 1'b1;
                r_start <= r_is_start;
                r_state <= S_DONE_WAIT;
`endif
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_byte_ok) begin
              r_wr_en     <= 1'b1;
              r_wr_addr   <= r_addr;
              r_wr_data   <= bus.byte_in;
              r_addr      <= r_addr + ADDR_WIDTH'(1);
              r_remaining <= r_remaining - 8'd1;
`ifdef SPI_FRAME_CSUM_EN
              r_csum      <= r_csum ^ bus.byte_in;
              if (r_remaining == 8'd1) r_state <= S_CSUM;
`else
              // Completion waits a cycle so it never coincides with the last write.
              if (r_remaining == 8'd1) r_state <= S_CMPL;
`endif
            end
          end
`ifdef SPI_FRAME_CSUM_EN
          S_CSUM: begin
            if (w_byte_ok) begin
              if (bus.byte_in == r_csum) begin
                r_done  <= 1'b1;
                r_start <= r_is_start;
                r_state <= S_DONE_WAIT;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= 2'd3;
                r_state    <= S_DROP;
              end
            end
          end
`endif
          S_CMPL: begin
            r_done  <= 1'b1;
            r_start <= r_is_start;
            r_state <= S_DONE_WAIT;
          end
          S_DONE_WAIT, S_DROP: ;
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.wr_en_out      = r_wr_en;
  assign bus.wr_addr_out    = r_wr_addr;
  assign bus.wr_data_out    = r_wr_data;
  assign bus.start_out      = r_start;
  assign bus.frame_done_out = r_done;
  assign bus.err_out        = r_err;
  assign bus.err_code_out   = r_err_code;
  assign bus.busy_out       = r_busy;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: one 8-bit-address and one 4-bit-address instance share stimulus.
// Output pulses are logged each falling edge with a cycle stamp and checked by scenario tasks.
module tb_spi_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tb_byte = 8'h00;
  logic       tb_valid = 1'b0;
  logic       tb_sel = 1'b1;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         last_cyc;
  int         desel_cyc;
  int         excl_viol = 0;
  logic [7:0] tb_csum;

  int         wr_cyc[$];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [3:0] w4_addr_q[$];
  logic [7:0] w4_data_q[$];
  int         done_q[$];
  int         start_q[$];
  int         err_cyc_q[$];
  logic [1:0] err_code_q[$];

  spi_frame_ctrl_if #(.ADDR_WIDTH(8)) if8 ();
  spi_frame_ctrl_if #(.ADDR_WIDTH(4)) if4 ();

  assign if8.byte_in = tb_byte;
  assign if8.byte_valid_in = tb_valid;
  assign if8.sel_in = tb_sel;
  assign if4.byte_in = tb_byte;
  assign if4.byte_valid_in = tb_valid;
  assign if4.sel_in = tb_sel;

  spi_frame_ctrl #(.ADDR_WIDTH(8)) u_dut8 (.clk_in(clk), .rst_n_in(rst_n), .bus(if8.slave));
  spi_frame_ctrl #(.ADDR_WIDTH(4)) u_dut4 (.clk_in(clk), .rst_n_in(rst_n), .bus(if4.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if8.wr_en_out === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr_q.push_back(if8.wr_addr_out);
      wr_data_q.push_back(if8.wr_data_out);
    end
    if (if4.wr_en_out === 1'b1) begin
      w4_addr_q.push_back(if4.wr_addr_out);
      w4_data_q.push_back(if4.wr_data_out);
    end
    if (if8.frame_done_out === 1'b1) done_q.push_back(cyc);
    if (if8.start_out === 1'b1) start_q.push_back(cyc);
    if (if8.err_out === 1'b1) begin
      err_cyc_q.push_back(cyc);
      err_code_q.push_back(if8.err_code_out);
    end
    if (if8.wr_en_out === 1'b1 && if8.frame_done_out === 1'b1) excl_viol++;
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr_q.delete(); wr_data_q.delete();
    w4_addr_q.delete(); w4_data_q.delete();
    done_q.delete(); start_q.delete(); err_cyc_q.delete(); err_code_q.delete();
    tb_csum = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tb_byte = b;
    tb_valid = 1'b1;
    tb_csum = tb_csum ^ b;
    last_cyc = cyc;
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  task automatic deselect();
    @(negedge clk);
    tb_sel = 1'b1;
    desel_cyc = cyc;
    @(negedge clk);
    @(negedge clk);
    tb_sel = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({if8.wr_en_out, if8.frame_done_out, if8.start_out, if8.err_out, if8.busy_out} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=00000",
        {if8.wr_en_out, if8.frame_done_out, if8.start_out, if8.err_out, if8.busy_out});
    end
    total++;
    if ({if8.wr_addr_out, if8.wr_data_out, if8.err_code_out} !== 18'h0) begin
      bad++; $display("FAIL reset_values got=%h exp=0", {if8.wr_addr_out, if8.wr_data_out, if8.err_code_out});
    end
  endtask

  task automatic test_write_burst();
    int t [6];
    int exp_done;
    clear_logs();
    send(8'h01); t[0] = last_cyc;
    send(8'h10); t[1] = last_cyc;
    send(8'h03); t[2] = last_cyc;
    send(8'hAA); t[3] = last_cyc;
    send(8'hBB); t[4] = last_cyc;
    send(8'hCC); t[5] = last_cyc;
    exp_done = t[5] + 2;
`ifdef SPI_FRAME_CSUM_EN
    send(tb_csum);
    exp_done = last_cyc + 1;
`endif
    repeat (3) @(negedge clk);
    total++;
    if (wr_cyc.size() !== 3) begin bad++; $display("FAIL burst_wr_count got=%0d exp=3", wr_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr_q[i] !== 8'h10 + 8'(i) || wr_cyc[i] !== t[3+i] + 1) begin
        bad++; $display("FAIL burst_wr%0d addr/cyc got=%h/%0d exp=%h/%0d", i, wr_addr_q[i], wr_cyc[i], 8'h10 + 8'(i), t[3+i] + 1);
      end
    end
    total++;
    if ({wr_data_q[0], wr_data_q[1], wr_data_q[2]} !== 24'hAABBCC) begin
      bad++; $display("FAIL burst_data got=%h exp=aabbcc", {wr_data_q[0], wr_data_q[1], wr_data_q[2]});
    end
    total++;
    if (done_q.size() !== 1 || done_q[0] !== exp_done) begin
      bad++; $display("FAIL burst_done got=%0d@%0d exp=1@%0d", done_q.size(), done_q[0], exp_done);
    end
    total++;
    if (if8.busy_out !== 1'b1) begin bad++; $display("FAIL burst_busy_held got=%b exp=1", if8.busy_out); end
    deselect();
    total++;
    if (if8.busy_out !== 1'b0 || err_cyc_q.size() !== 0 || start_q.size() !== 0) begin
      bad++; $display("FAIL burst_after_desel busy/err/start got=%b/%0d/%0d exp=0/0/0", if8.busy_out, err_cyc_q.size(), start_q.size());
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    send(8'h01); send(8'h0F); send(8'h02); send(8'h11); send(8'h22);
`ifdef SPI_FRAME_CSUM_EN
    send(tb_csum);
`endif
    repeat (3) @(negedge clk);
    total++;
    if (w4_addr_q.size() !== 2 || {w4_addr_q[0], w4_addr_q[1]} !== 8'hF0) begin
      bad++; $display("FAIL wrap_addr got=%0d:%h%h exp=2:f0", w4_addr_q.size(), w4_addr_q[0], w4_addr_q[1]);
    end
    total++;
    if ({w4_data_q[0], w4_data_q[1]} !== 16'h1122) begin
      bad++; $display("FAIL wrap_data got=%h%h exp=1122", w4_data_q[0], w4_data_q[1]);
    end
    deselect();
  endtask

  task automatic test_start();
    clear_logs();
    send(8'h02); send(8'h00); send(8'h00);
`ifdef SPI_FRAME_CSUM_EN
    send(tb_csum);
`endif
    repeat (3) @(negedge clk);
    total++;
    if (start_q.size() !== 1 || done_q.size() !== 1 || start_q[0] !== last_cyc + 1 || done_q[0] !== last_cyc + 1) begin
      bad++; $display("FAIL start_pulse got=%0d@%0d/%0d@%0d exp=1@%0d", start_q.size(), start_q[0], done_q.size(), done_q[0], last_cyc + 1);
    end
    total++;
    if (wr_cyc.size() !== 0) begin bad++; $display("FAIL start_no_write got=%0d exp=0", wr_cyc.size()); end
    deselect();
    clear_logs();
    send(8'h02); send(8'h00); send(8'h01);
    repeat (3) @(negedge clk);
    total++;
    if (err_cyc_q.size() !== 1 || err_code_q[0] !== 2'd1 || err_cyc_q[0] !== last_cyc + 1) begin
      bad++; $display("FAIL start_len_err got=%0d code=%0d@%0d exp=1 code=1@%0d", err_cyc_q.size(), err_code_q[0], err_cyc_q[0], last_cyc + 1);
    end
    total++;
    if (start_q.size() !== 0 || done_q.size() !== 0) begin
      bad++; $display("FAIL start_len_nostart got=%0d/%0d exp=0/0", start_q.size(), done_q.size());
    end
    deselect();
  endtask

  task automatic test_bad_opcode();
    int t0;
    clear_logs();
    send(8'h7F); t0 = last_cyc;
    send(8'h01); send(8'h02);
    deselect();
    total++;
    if (err_cyc_q.size() !== 1 || err_code_q[0] !== 2'd1 || err_cyc_q[0] !== t0 + 1) begin
      bad++; $display("FAIL bad_opcode got=%0d code=%0d@%0d exp=1 code=1@%0d", err_cyc_q.size(), err_code_q[0], err_cyc_q[0], t0 + 1);
    end
    total++;
    if (wr_cyc.size() !== 0 || done_q.size() !== 0) begin
      bad++; $display("FAIL bad_opcode_quiet got=%0d/%0d exp=0/0", wr_cyc.size(), done_q.size());
    end
  endtask

  task automatic test_truncation();
    clear_logs();
    send(8'h01); send(8'h20); send(8'h04); send(8'h55);
    deselect();
    repeat (4) @(negedge clk);
    total++;
    if (wr_cyc.size() !== 1 || wr_addr_q[0] !== 8'h20 || wr_data_q[0] !== 8'h55) begin
      bad++; $display("FAIL trunc_write got=%0d %h:%h exp=1 20:55", wr_cyc.size(), wr_addr_q[0], wr_data_q[0]);
    end
    total++;
    if (err_cyc_q.size() !== 1 || err_code_q[0] !== 2'd2 || err_cyc_q[0] !== desel_cyc + 1) begin
      bad++; $display("FAIL trunc_err got=%0d code=%0d@%0d exp=1 code=2@%0d", err_cyc_q.size(), err_code_q[0], err_cyc_q[0], desel_cyc + 1);
    end
    total++;
    if (if8.err_code_out !== 2'd2 || if8.err_out !== 1'b0) begin
      bad++; $display("FAIL trunc_code_held got=%0d/%b exp=2/0", if8.err_code_out, if8.err_out);
    end
  endtask

`ifdef SPI_FRAME_CSUM_EN
  task automatic test_checksum();
    clear_logs();
    send(8'h01); send(8'h00); send(8'h01); send(8'h5A); send(8'h5B);
    repeat (3) @(negedge clk);
    total++;
    if (wr_cyc.size() !== 1 || err_cyc_q.size() !== 1 || err_code_q[0] !== 2'd3 || done_q.size() !== 0) begin
      bad++; $display("FAIL csum_bad wr=%0d err=%0d code=%0d done=%0d exp=1/1/3/0", wr_cyc.size(), err_cyc_q.size(), err_code_q[0], done_q.size());
    end
    deselect();
    clear_logs();
    send(8'h01); send(8'h00); send(8'h01); send(8'h5A); send(8'h5A);
    repeat (3) @(negedge clk);
    total++;
    if (done_q.size() !== 1 || done_q[0] !== last_cyc + 1 || err_cyc_q.size() !== 0) begin
      bad++; $display("FAIL csum_good done=%0d@%0d err=%0d exp=1@%0d err=0", done_q.size(), done_q[0], err_cyc_q.size(), last_cyc + 1);
    end
    deselect();
  endtask
`else
  task automatic test_len_zero();
    clear_logs();
    send(8'h01); send(8'h44); send(8'h00);
    send(8'h5B);
    repeat (3) @(negedge clk);
    total++;
    if (done_q.size() !== 1 || done_q[0] !== last_cyc - 1 || err_cyc_q.size() !== 0 || wr_cyc.size() !== 0) begin
      bad++; $display("FAIL len_zero done=%0d@%0d err=%0d wr=%0d exp=1@%0d 0 0", done_q.size(), done_q[0], err_cyc_q.size(), wr_cyc.size(), last_cyc - 1);
    end
    deselect();
  endtask
`endif

  task automatic test_reset_mid_frame();
    clear_logs();
    send(8'h01); send(8'h30); send(8'h03); send(8'h11);
    #2;
    total++;
    if (if8.wr_en_out !== 1'b1 || if8.busy_out !== 1'b1) begin
      bad++; $display("FAIL rst_pre wr/busy got=%b/%b exp=1/1", if8.wr_en_out, if8.busy_out);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({if8.wr_en_out, if8.busy_out, if8.err_out, if8.err_code_out, if8.wr_addr_out} !== 13'h0) begin
      bad++; $display("FAIL rst_async got=%h exp=0", {if8.wr_en_out, if8.busy_out, if8.err_out, if8.err_code_out, if8.wr_addr_out});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    send(8'h01); send(8'h40); send(8'h01); send(8'h77);
`ifdef SPI_FRAME_CSUM_EN
    send(tb_csum);
`endif
    repeat (3) @(negedge clk);
    total++;
    if (wr_cyc.size() !== 1 || wr_addr_q[0] !== 8'h40 || wr_data_q[0] !== 8'h77 || done_q.size() !== 1) begin
      bad++; $display("FAIL rst_fresh wr=%0d %h:%h done=%0d exp=1 40:77 1", wr_cyc.size(), wr_addr_q[0], wr_data_q[0], done_q.size());
    end
    total++;
    if (err_cyc_q.size() !== 0) begin bad++; $display("FAIL rst_no_err got=%0d exp=0", err_cyc_q.size()); end
    deselect();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    tb_sel = 1'b0;
    test_write_burst();
    test_wrap();
    test_start();
    test_bad_opcode();
    test_truncation();
`ifdef SPI_FRAME_CSUM_EN
    test_checksum();
`else
    test_len_zero();
`endif
    test_reset_mid_frame();
    total++;
    if (excl_viol !== 0) begin bad++; $display("FAIL wr_done_exclusive got=%0d exp=0", excl_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
